uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_fifo_mem.sv | 19 +
 rtl/uart_rx_fifo.sv | 59 +++++
 tb/tb_uart_rx_fifo.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths, FIFO defaults and baud-divider constants
package uart_pkg;
  localparam int BYTE_W       = 8;
  localparam int DEPTH        = 16;
  localparam int ADDR_W       = 4;
  localparam int CLKS_PER_BIT = 434;
  localparam int HALF_BIT     = 217;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x BYTE_W storage with synchronous write and asynchronous read
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = uart_pkg::DEPTH,
  parameter int ADDR_W = uart_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);
  logic [BYTE_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: edge-triggered capture of received bytes into a FWFT FIFO with sticky overflow
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = uart_pkg::DEPTH,
  parameter int ADDR_W    = uart_pkg::ADDR_W,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              rx_done,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              overflow,
  input  logic              ovf_clear
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic [BYTE_W-1:0] mem_rdata;
  logic              prev_done, push, pop, full, wr_en, drop;
  always_comb begin
    push      = rx_done & ~prev_done;
    pop       = rd_valid & rd_ready;
    full      = count == (ADDR_W+1)'(DEPTH);
    wr_en     = push & (~full | pop);
    drop      = push & full & ~pop;
    count_nxt = count + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
    rd_valid  = count != '0;
    rd_data   = rd_valid ? mem_rdata : '0;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      prev_done   <= 1'b1;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      prev_done   <= rx_done;
      wr_ptr      <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count       <= count_nxt;
      almost_full <= count_nxt >= (ADDR_W+1)'(AFULL_LVL);
      overflow    <= drop ? 1'b1 : ovf_clear ? 1'b0 : overflow;
    end
  uart_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (rx_byte),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard-driven self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       clk = 1'b0, reset = 1'b0, rx_done = 1'b1, rd_ready = 1'b0, ovf_clear = 1'b0;
  logic [7:0] rx_byte = 8'hA5;
  logic [7:0] rd_data;
  logic       rd_valid, almost_full, overflow;
  logic [4:0] count;
  logic [7:0] q[$];
  logic       m_prev = 1'b1, m_ovf = 1'b0;
  logic [7:0] last_pop = 8'h00;
  int         n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  uart_rx_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .rx_byte     (rx_byte),
    .rx_done     (rx_done),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow),
    .ovf_clear   (ovf_clear)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    logic push, pop, drop;
    logic [7:0] e;
    if (!reset) begin
      q.delete();
      m_prev = 1'b1;
      m_ovf  = 1'b0;
    end else begin
      push = rx_done & ~m_prev;
      pop  = (q.size() != 0) & rd_ready;
      if (pop) begin
        e = q.pop_front();
        last_pop = e;
        check("pop_data", rd_data, e);
      end
      drop = push && q.size() == 16;
      if (push && !drop) q.push_back(rx_byte);
      if (drop) m_ovf = 1'b1;
      else if (ovf_clear) m_ovf = 1'b0;
      m_prev = rx_done;
    end
    @(posedge clk);
    #1;
    check("count", count, q.size());
    check("rd_valid", rd_valid, q.size() != 0);
    check("rd_data", rd_data, q.size() != 0 ? q[0] : 8'h00);
    check("almost_full", almost_full, q.size() >= 12);
    check("overflow", overflow, m_ovf);
    @(negedge clk);
  endtask
  task automatic strobe(input logic [7:0] b);
    rx_done = 1'b0;
    step();
    rx_done = 1'b1;
    rx_byte = b;
    step();
  endtask
  initial begin
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 8'h00);
    strobe(8'h41);
    check("latency", rd_valid, 1);
    strobe(8'h42);
    strobe(8'h43);
    check("cnt3", count, 3);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("cnt_seq", count, 2 - i);
    end
    check("last_43", last_pop, 8'h43);
    rd_ready = 1'b0;
    rx_done  = 1'b0;
    step();
    rx_done = 1'b1;
    rx_byte = 8'h55;
    repeat (5) step();
    check("hold_one", count, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      strobe(8'(i));
      if (i == 10) check("afull_11", almost_full, 0);
      if (i == 11) check("afull_12", almost_full, 1);
    end
    strobe(8'hFF);
    check("ovf_set", overflow, 1);
    check("full_cnt", count, 16);
    rx_done   = 1'b0;
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    check("ovf_clr", overflow, 0);
    rd_ready = 1'b1;
    rx_done  = 1'b1;
    rx_byte  = 8'h99;
    step();
    check("pp_ovf", overflow, 0);
    check("pp_cnt", count, 16);
    check("pp_pop", last_pop, 8'h00);
    rx_done = 1'b0;
    repeat (16) step();
    check("last_99", last_pop, 8'h99);
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) strobe(8'(8'h20 + i));
    rx_done = 1'b0;
    step();
    rx_done   = 1'b1;
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    check("set_wins", overflow, 1);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    check("clr_alone", overflow, 0);
    rd_ready = 1'b1;
    repeat (11) step();
    rd_ready = 1'b0;
    check("five_left", count, 5);
    reset = 1'b0;
    step();
    check("mid_rst_cnt", count, 0);
    check("mid_rst_valid", rd_valid, 0);
    reset = 1'b1;
    repeat (3) step();
    check("no_push_after_rst", count, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
